// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcodes, encodings and control bundle for the RV32I/E decode stage
package decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;
    localparam logic [3:0] ALU_ADDPC = 4'd11;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [3:0] alu_control;
        logic       alu_src;
        logic       jalr_instr;
        logic [2:0] addressing_control;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Operand usage drives both the load-use check and the RV32E index check.
    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R || op == OP_STORE || op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/control_unit.sv
// rtl/control_unit.sv - main opcode decoder producing the E control bundle and immediate format
module control_unit
    import decode_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output ctrl_t      ctrl,
    output logic [2:0] imm_src
);

    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        imm_src = IMM_I;
        case (op)
            OP_LOAD: begin
                ctrl.reg_write          = 1'b1;
                ctrl.result_src         = RES_MEM;
                ctrl.alu_src            = 1'b1;
                ctrl.addressing_control = funct3;
            end
            OP_STORE: begin
                ctrl.mem_write          = 1'b1;
                ctrl.alu_src            = 1'b1;
                ctrl.addressing_control = funct3;
                imm_src                 = IMM_S;
            end
            OP_BRANCH: begin
                ctrl.branch             = 1'b1;
                ctrl.alu_control        = ALU_SUB;
                ctrl.addressing_control = funct3;
                imm_src                 = IMM_B;
            end
            OP_R: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_control = alu_decode(funct3, funct7b5);
            end
            OP_I: begin
                // Only SRAI carries the alternate bit; ADDI has no subtract form.
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = alu_decode(funct3, funct3 == 3'd5 && funct7b5);
            end
            OP_LUI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_PASSB;
                imm_src          = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_ADDPC;
                imm_src          = IMM_U;
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.jump       = 1'b1;
                imm_src         = IMM_J;
            end
            OP_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.jump       = 1'b1;
                ctrl.jalr_instr = 1'b1;
                ctrl.alu_src    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/extend.sv
// rtl/extend.sv - immediate extraction and sign extension to the datapath width
module extend
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:7]           instr,
    input  logic [2:0]            imm_src,
    output logic [DATA_WIDTH-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_src)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = DATA_WIDTH'($signed(imm32));

endmodule

// File: rtl/regfile_np.sv
// rtl/regfile_np.sv - NUM_REGS x DATA_WIDTH 2R1W register file with debug port; WB_BYPASS_EN enables write-through
module regfile_np #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  we,
    input  logic [4:0]            wa,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [4:0]            ra1,
    input  logic [4:0]            ra2,
    input  logic [4:0]            ra3,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    output logic [DATA_WIDTH-1:0] rd3
);

    localparam int REG_AW = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    function automatic logic in_range(input logic [4:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    // x0 and indices beyond the implemented file both read as zero.
    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [4:0] a);
        if (a == 5'd0 || !in_range(a)) return '0;
        return regs[a[REG_AW-1:0]];
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0 && in_range(wa)) begin
            regs[wa[REG_AW-1:0]] <= wd;
        end
    end

`ifdef WB_BYPASS_EN
    logic wb_hit_ok;
    assign wb_hit_ok = we && wa != 5'd0 && in_range(wa);
    assign rd1 = (wb_hit_ok && wa == ra1) ? wd : read_port(ra1);
    assign rd2 = (wb_hit_ok && wa == ra2) ? wd : read_port(ra2);
`else
    assign rd1 = read_port(ra1);
    assign rd2 = read_port(ra2);
`endif
    assign rd3 = read_port(ra3);

endmodule

// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - RV32I/E decode with ID/EX register, handshake, flush and load-use bubble
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [31:0]           instrD,
    input  logic [DATA_WIDTH-1:0] pcD,
    input  logic                  flush_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    input  logic                  RegWriteW,
    input  logic [4:0]            RdW,
    input  logic [DATA_WIDTH-1:0] ResultW,
    input  logic [4:0]            testRegAddress,
    output logic [DATA_WIDTH-1:0] testRegData,
    output logic                  RegWriteE,
    output logic [1:0]            ResultSrcE,
    output logic                  MemWriteE,
    output logic                  JumpE,
    output logic                  BranchE,
    output logic [3:0]            ALUControlE,
    output logic                  ALUSrcE,
    output logic                  JALRInstrE,
    output logic [2:0]            AddressingControlE,
    output logic [DATA_WIDTH-1:0] RD1E,
    output logic [DATA_WIDTH-1:0] RD2E,
    output logic [DATA_WIDTH-1:0] ExtImmE,
    output logic [DATA_WIDTH-1:0] pcE,
    output logic [4:0]            Rs1E,
    output logic [4:0]            Rs2E,
    output logic [4:0]            RdE,
    output logic                  illegalE,
    output logic                  load_use_stall_o
);

    localparam int REG_AW = $clog2(NUM_REGS);

    logic [6:0]            op;
    logic [4:0]            rs1_d, rs2_d, rd_d;
    ctrl_t                 ctrl_d, ctrl_eff, ctrl_e;
    logic [2:0]            imm_src;
    logic [DATA_WIDTH-1:0] imm_d, rd1_d, rd2_d;
    logic                  has_rd, illegal_d, hazard, advance, take;

    assign op    = instrD[6:0];
    assign rd_d  = instrD[11:7];
    assign rs1_d = instrD[19:15];
    assign rs2_d = instrD[24:20];

    function automatic logic out_of_range(input logic [4:0] a);
        return (a >> REG_AW) != 5'd0;
    endfunction

    control_unit u_ctrl (
        .op       (op),
        .funct3   (instrD[14:12]),
        .funct7b5 (instrD[30]),
        .ctrl     (ctrl_d),
        .imm_src  (imm_src)
    );

    extend #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
        .instr   (instrD[31:7]),
        .imm_src (imm_src),
        .imm     (imm_d)
    );

    regfile_np #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_rf (
        .clk    (clk),
        .resetn (reset),
        .we     (RegWriteW),
        .wa     (RdW),
        .wd     (ResultW),
        .ra1    (rs1_d),
        .ra2    (rs2_d),
        .ra3    (testRegAddress),
        .rd1    (rd1_d),
        .rd2    (rd2_d),
        .rd3    (testRegData)
    );

    // Only index fields the opcode actually uses count as register references.
    assign has_rd    = !(op == OP_STORE || op == OP_BRANCH);
    assign illegal_d = (uses_rs1(op) && out_of_range(rs1_d)) ||
                       (uses_rs2(op) && out_of_range(rs2_d)) ||
                       (has_rd && out_of_range(rd_d));

    always_comb begin
        ctrl_eff = ctrl_d;
        if (rd_d == 5'd0 || illegal_d) ctrl_eff.reg_write = 1'b0;
        if (illegal_d)                 ctrl_eff.mem_write = 1'b0;
    end

    assign hazard = valid_o && valid_i && ctrl_e.result_src == RES_MEM && RdE != 5'd0 &&
                    ((uses_rs1(op) && RdE == rs1_d) || (uses_rs2(op) && RdE == rs2_d));

    assign advance          = !valid_o || ready_i;
    assign take             = valid_i && !hazard;
    assign ready_o          = reset && (flush_i || (advance && !hazard));
    assign load_use_stall_o = reset && !flush_i && hazard;

    // Reset and flush both empty E; an advance without a transfer loads a zeroed bubble.
    always_ff @(posedge clk) begin
        if (!reset || flush_i) begin
            valid_o  <= 1'b0;
            ctrl_e   <= CTRL_BUBBLE;
            RD1E     <= '0;
            RD2E     <= '0;
            ExtImmE  <= '0;
            pcE      <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
            illegalE <= 1'b0;
        end else if (advance) begin
            valid_o  <= take;
            ctrl_e   <= take ? ctrl_eff : CTRL_BUBBLE;
            RD1E     <= take ? rd1_d : '0;
            RD2E     <= take ? rd2_d : '0;
            ExtImmE  <= take ? imm_d : '0;
            pcE      <= take ? pcD : '0;
            Rs1E     <= take ? rs1_d : '0;
            Rs2E     <= take ? rs2_d : '0;
            RdE      <= take ? rd_d : '0;
            illegalE <= take && illegal_d;
        end
    end

    assign RegWriteE          = ctrl_e.reg_write;
    assign ResultSrcE         = ctrl_e.result_src;
    assign MemWriteE          = ctrl_e.mem_write;
    assign JumpE              = ctrl_e.jump;
    assign BranchE            = ctrl_e.branch;
    assign ALUControlE        = ctrl_e.alu_control;
    assign ALUSrcE            = ctrl_e.alu_src;
    assign JALRInstrE         = ctrl_e.jalr_instr;
    assign AddressingControlE = ctrl_e.addressing_control;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - directed bench for decode_stage_pipe (RV32I and RV32E instances)
module tb_decode_stage_pipe;

    localparam int DW = 32;
    localparam logic [31:0] I_ADDI_X1_5  = 32'h0050_0093;
    localparam logic [31:0] I_ADD_X2_X1  = 32'h0010_8133;
    localparam logic [31:0] I_LW_X3      = 32'h0000_2183;
    localparam logic [31:0] I_ADD_X4_X3  = 32'h0001_8233;
    localparam logic [31:0] I_ADDI_X5_7  = 32'h0070_0293;
    localparam logic [31:0] I_ADD_X17    = 32'h0020_88B3;
    localparam logic [31:0] I_ADDI_X0_1  = 32'h0010_0013;
`ifdef WB_BYPASS_EN
    localparam logic [DW-1:0] BYP_EXP = 32'd5;
`else
    localparam logic [DW-1:0] BYP_EXP = 32'd0;
`endif

    logic clk = 1'b0;
    logic reset, valid_i, flush_i, ready_i, RegWriteW;
    logic [31:0] instrD;
    logic [DW-1:0] pcD, ResultW;
    logic [4:0] RdW, testRegAddress;

    logic ready_o, valid_o, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRInstrE, illegalE, load_use_stall_o;
    logic [1:0] ResultSrcE;
    logic [3:0] ALUControlE;
    logic [2:0] AddressingControlE;
    logic [DW-1:0] testRegData, RD1E, RD2E, ExtImmE, pcE;
    logic [4:0] Rs1E, Rs2E, RdE;

    logic ready_o_16, valid_o_16, RegWriteE_16, MemWriteE_16, JumpE_16, BranchE_16, ALUSrcE_16, JALRInstrE_16, illegalE_16, stall_16;
    logic [1:0] ResultSrcE_16;
    logic [3:0] ALUControlE_16;
    logic [2:0] AddressingControlE_16;
    logic [DW-1:0] testRegData_16, RD1E_16, RD2E_16, ExtImmE_16, pcE_16;
    logic [4:0] Rs1E_16, Rs2E_16, RdE_16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decode_stage_pipe #(.DATA_WIDTH(DW), .NUM_REGS(32)) u_dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o), .instrD(instrD), .pcD(pcD),
        .flush_i(flush_i), .ready_i(ready_i), .valid_o(valid_o), .RegWriteW(RegWriteW), .RdW(RdW),
        .ResultW(ResultW), .testRegAddress(testRegAddress), .testRegData(testRegData),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .JALRInstrE(JALRInstrE),
        .AddressingControlE(AddressingControlE), .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .pcE(pcE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .illegalE(illegalE), .load_use_stall_o(load_use_stall_o)
    );

    decode_stage_pipe #(.DATA_WIDTH(DW), .NUM_REGS(16)) u_dut16 (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o_16), .instrD(instrD), .pcD(pcD),
        .flush_i(flush_i), .ready_i(ready_i), .valid_o(valid_o_16), .RegWriteW(RegWriteW), .RdW(RdW),
        .ResultW(ResultW), .testRegAddress(testRegAddress), .testRegData(testRegData_16),
        .RegWriteE(RegWriteE_16), .ResultSrcE(ResultSrcE_16), .MemWriteE(MemWriteE_16), .JumpE(JumpE_16),
        .BranchE(BranchE_16), .ALUControlE(ALUControlE_16), .ALUSrcE(ALUSrcE_16), .JALRInstrE(JALRInstrE_16),
        .AddressingControlE(AddressingControlE_16), .RD1E(RD1E_16), .RD2E(RD2E_16), .ExtImmE(ExtImmE_16),
        .pcE(pcE_16), .Rs1E(Rs1E_16), .Rs2E(Rs2E_16), .RdE(RdE_16), .illegalE(illegalE_16),
        .load_use_stall_o(stall_16)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1; RegWriteW = 1'b0;
        instrD = '0; pcD = '0; ResultW = '0; RdW = '0; testRegAddress = 5'd1;
        #2;
        tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL rst_ready got %b exp 0", ready_o); end
        step; step;
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", valid_o); end
        tests++; if (RegWriteE !== 1'b0) begin fails++; $display("FAIL rst_regwrite got %b exp 0", RegWriteE); end
        tests++; if (RD1E !== 32'd0) begin fails++; $display("FAIL rst_rd1 got %h exp 0", RD1E); end
        tests++; if (pcE !== 32'd0) begin fails++; $display("FAIL rst_pc got %h exp 0", pcE); end
        tests++; if (testRegData !== 32'd0) begin fails++; $display("FAIL rst_dbg got %h exp 0", testRegData); end
        reset = 1'b1;
        #1;
        tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b exp 1", ready_o); end
    endtask

    task automatic test_bypass;
        valid_i = 1'b1; instrD = I_ADDI_X1_5; pcD = 32'h100;
        step;
        tests++; if (valid_o !== 1'b1) begin fails++; $display("FAIL addi_valid got %b exp 1", valid_o); end
        tests++; if (RegWriteE !== 1'b1) begin fails++; $display("FAIL addi_regwrite got %b exp 1", RegWriteE); end
        tests++; if (RdE !== 5'd1) begin fails++; $display("FAIL addi_rd got %0d exp 1", RdE); end
        tests++; if (ExtImmE !== 32'd5) begin fails++; $display("FAIL addi_imm got %h exp 5", ExtImmE); end
        tests++; if (ALUSrcE !== 1'b1) begin fails++; $display("FAIL addi_alusrc got %b exp 1", ALUSrcE); end
        tests++; if (pcE !== 32'h100) begin fails++; $display("FAIL addi_pc got %h exp 100", pcE); end
        instrD = I_ADD_X2_X1; pcD = 32'h104;
        RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'd5;
        #1;
        tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL add_ready got %b exp 1", ready_o); end
        step;
        RegWriteW = 1'b0;
        tests++; if (RD1E !== BYP_EXP) begin fails++; $display("FAIL add_rd1 got %h exp %h", RD1E, BYP_EXP); end
        tests++; if (RD2E !== BYP_EXP) begin fails++; $display("FAIL add_rd2 got %h exp %h", RD2E, BYP_EXP); end
        tests++; if (RegWriteE !== 1'b1) begin fails++; $display("FAIL add_regwrite got %b exp 1", RegWriteE); end
        tests++; if (ALUSrcE !== 1'b0) begin fails++; $display("FAIL add_alusrc got %b exp 0", ALUSrcE); end
        tests++; if (Rs1E !== 5'd1 || Rs2E !== 5'd1 || RdE !== 5'd2) begin fails++; $display("FAIL add_idx got %0d/%0d/%0d exp 1/1/2", Rs1E, Rs2E, RdE); end
        testRegAddress = 5'd1;
        #1;
        tests++; if (testRegData !== 32'd5) begin fails++; $display("FAIL wb_x1 got %h exp 5", testRegData); end
    endtask

    task automatic test_load_use;
        instrD = I_LW_X3; pcD = 32'h108;
        step;
        tests++; if (ResultSrcE !== 2'b01) begin fails++; $display("FAIL lw_ressrc got %b exp 01", ResultSrcE); end
        tests++; if (AddressingControlE !== 3'b010) begin fails++; $display("FAIL lw_addr got %b exp 010", AddressingControlE); end
        tests++; if (RdE !== 5'd3 || valid_o !== 1'b1) begin fails++; $display("FAIL lw_rd got %0d v%b exp 3 v1", RdE, valid_o); end
        instrD = I_ADD_X4_X3; pcD = 32'h10C;
        #1;
        tests++; if (load_use_stall_o !== 1'b1) begin fails++; $display("FAIL lu_stall got %b exp 1", load_use_stall_o); end
        tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL lu_ready got %b exp 0", ready_o); end
        step;
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL lu_bubble_valid got %b exp 0", valid_o); end
        tests++; if (RegWriteE !== 1'b0 || RdE !== 5'd0) begin fails++; $display("FAIL lu_bubble_ctrl got %b/%0d exp 0/0", RegWriteE, RdE); end
        tests++; if (load_use_stall_o !== 1'b0) begin fails++; $display("FAIL lu_stall_len got %b exp 0", load_use_stall_o); end
        tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL lu_ready2 got %b exp 1", ready_o); end
        step;
        tests++; if (valid_o !== 1'b1 || RdE !== 5'd4) begin fails++; $display("FAIL lu_issue got v%b rd%0d exp v1 rd4", valid_o, RdE); end
        tests++; if (Rs1E !== 5'd3 || pcE !== 32'h10C) begin fails++; $display("FAIL lu_issue_src got %0d/%h exp 3/10c", Rs1E, pcE); end
    endtask

    task automatic test_back_pressure;
        ready_i = 1'b0; instrD = I_ADDI_X5_7; pcD = 32'h110;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d] got %b exp 0", i, ready_o); end
            step;
            tests++; if (RdE !== 5'd4 || pcE !== 32'h10C || valid_o !== 1'b1) begin fails++; $display("FAIL bp_hold[%0d] got rd%0d pc%h v%b exp rd4 pc10c v1", i, RdE, pcE, valid_o); end
        end
        ready_i = 1'b1;
        #1;
        tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL bp_resume_ready got %b exp 1", ready_o); end
        step;
        tests++; if (RdE !== 5'd5 || ExtImmE !== 32'd7 || pcE !== 32'h110) begin fails++; $display("FAIL bp_next got rd%0d imm%h pc%h exp rd5 imm7 pc110", RdE, ExtImmE, pcE); end
        valid_i = 1'b0;
        step;
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL bp_nodup got %b exp 0", valid_o); end
    endtask

    task automatic test_flush;
        valid_i = 1'b1; instrD = I_LW_X3; pcD = 32'h120;
        step;
        instrD = I_ADD_X4_X3; pcD = 32'h124;
        #1;
        tests++; if (load_use_stall_o !== 1'b1) begin fails++; $display("FAIL fl_prestall got %b exp 1", load_use_stall_o); end
        flush_i = 1'b1;
        #1;
        tests++; if (load_use_stall_o !== 1'b0 || ready_o !== 1'b1) begin fails++; $display("FAIL fl_comb got stall%b ready%b exp stall0 ready1", load_use_stall_o, ready_o); end
        step;
        flush_i = 1'b0; valid_i = 1'b0;
        #1;
        tests++; if (valid_o !== 1'b0 || load_use_stall_o !== 1'b0) begin fails++; $display("FAIL fl_clear got v%b stall%b exp v0 stall0", valid_o, load_use_stall_o); end
        step;
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL fl_dropped got %b exp 0", valid_o); end
        valid_i = 1'b1; instrD = I_ADDI_X5_7; pcD = 32'h128;
        step;
        ready_i = 1'b0; flush_i = 1'b1;
        step;
        flush_i = 1'b0; valid_i = 1'b0;
        tests++; if (valid_o !== 1'b0 || RegWriteE !== 1'b0) begin fails++; $display("FAIL fl_noready got v%b rw%b exp v0 rw0", valid_o, RegWriteE); end
        ready_i = 1'b1;
    endtask

    task automatic test_rv32e;
        valid_i = 1'b1; instrD = I_ADD_X17; pcD = 32'h130;
        step;
        tests++; if (illegalE_16 !== 1'b1 || RegWriteE_16 !== 1'b0) begin fails++; $display("FAIL e_x17 got ill%b rw%b exp ill1 rw0", illegalE_16, RegWriteE_16); end
        tests++; if (illegalE !== 1'b0 || RegWriteE !== 1'b1) begin fails++; $display("FAIL i_x17 got ill%b rw%b exp ill0 rw1", illegalE, RegWriteE); end
        tests++; if (RdE_16 !== 5'd17) begin fails++; $display("FAIL e_x17_rd got %0d exp 17", RdE_16); end
        instrD = I_ADDI_X0_1; pcD = 32'h134;
        step;
        tests++; if (RegWriteE !== 1'b0 || RegWriteE_16 !== 1'b0) begin fails++; $display("FAIL x0_regwrite got %b/%b exp 0/0", RegWriteE, RegWriteE_16); end
        tests++; if (illegalE_16 !== 1'b0 || ExtImmE !== 32'd1) begin fails++; $display("FAIL x0_misc got ill%b imm%h exp ill0 imm1", illegalE_16, ExtImmE); end
        valid_i = 1'b0; RegWriteW = 1'b1; RdW = 5'd20; ResultW = 32'hABCD;
        step;
        RdW = 5'd0; ResultW = 32'h55;
        step;
        RegWriteW = 1'b0; testRegAddress = 5'd20;
        #1;
        tests++; if (testRegData !== 32'hABCD) begin fails++; $display("FAIL wr_x20 got %h exp abcd", testRegData); end
        tests++; if (testRegData_16 !== 32'd0) begin fails++; $display("FAIL e_wr_x20 got %h exp 0", testRegData_16); end
        testRegAddress = 5'd0;
        #1;
        tests++; if (testRegData !== 32'd0) begin fails++; $display("FAIL wr_x0 got %h exp 0", testRegData); end
    endtask

    task automatic test_reset_mid;
        testRegAddress = 5'd1;
        valid_i = 1'b1; instrD = I_ADDI_X5_7; pcD = 32'h140;
        step;
        tests++; if (valid_o !== 1'b1 || testRegData !== 32'd5) begin fails++; $display("FAIL mid_pre got v%b x1=%h exp v1 x1=5", valid_o, testRegData); end
        reset = 1'b0;
        #1;
        tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL mid_ready got %b exp 0", ready_o); end
        step;
        reset = 1'b1; valid_i = 1'b0;
        tests++; if (valid_o !== 1'b0 || RegWriteE !== 1'b0 || RdE !== 5'd0) begin fails++; $display("FAIL mid_ctrl got v%b rw%b rd%0d exp 0/0/0", valid_o, RegWriteE, RdE); end
        tests++; if (pcE !== 32'd0 || ExtImmE !== 32'd0 || ALUSrcE !== 1'b0) begin fails++; $display("FAIL mid_data got pc%h imm%h as%b exp 0", pcE, ExtImmE, ALUSrcE); end
        tests++; if (testRegData !== 32'd0) begin fails++; $display("FAIL mid_x1 got %h exp 0", testRegData); end
    endtask

    initial begin
        test_reset;
        test_bypass;
        test_load_use;
        test_back_pressure;
        test_flush;
        test_rv32e;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
